// File: rtl/mem_lsu.sv
// Memory-access stage: ALU pass-through, req/ack load/store bus, big-endian byte lanes.
// Optional macro MEM_ALIGN_EXC_EN turns misaligned halfword/word accesses into an excp_o pulse.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_rw_i,
    input  logic              mem_wreg_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [2:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_sdata_i,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_ack,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              stall_req,
    output logic [4:0]        wb_rw,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              excp_o
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
        OP_LHU  = 3'd4, OP_LW = 3'd5, OP_SB  = 3'd6, OP_SW = 3'd7
    } mem_op_e;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e            state;
    mem_op_e           op;
    mem_op_e           op_q;
    logic [1:0]        lo_q;
    logic              misalign;
    logic [3:0]        sel_c;
    logic [DATA_W-1:0] wdata_c;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_data;

    assign op = mem_op_e'(mem_op_i);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        misalign = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
        if ((op == OP_LH || op == OP_LHU) && mem_addr_i[0])
            misalign = 1'b1;
        if ((op == OP_LW || op == OP_SW) && mem_addr_i[1:0] != 2'b00)
            misalign = 1'b1;
`endif
    end

    always_comb begin
        sel_c   = 4'b0000;
        wdata_c = mem_sdata_i;
        case (op)
            OP_LB, OP_LBU, OP_SB: sel_c = 4'b1000 >> mem_addr_i[1:0];
            OP_LH, OP_LHU:        sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            OP_LW, OP_SW:         sel_c = 4'b1111;
            default:              sel_c = 4'b0000;
        endcase
        if (op == OP_SB)
            wdata_c = {4{mem_sdata_i[7:0]}};
    end

    // Lane pick uses the low address bits captured at request time; the bus address is word-aligned.
    always_comb begin
        case (lo_q)
            2'd0:    byte_v = dbus_rdata[31:24];
            2'd1:    byte_v = dbus_rdata[23:16];
            2'd2:    byte_v = dbus_rdata[15:8];
            default: byte_v = dbus_rdata[7:0];
        endcase
        half_v = lo_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
        case (op_q)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'd0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'd0, half_v};
            default: load_data = dbus_rdata;
        endcase
    end

    always_comb begin
        if (state == S_IDLE)
            stall_req = (op != OP_NONE) && !misalign;
        else
            stall_req = !dbus_ack;
    end

`ifdef MEM_ALIGN_EXC_EN
    logic excp_q;
    assign excp_o = excp_q;
`else
    assign excp_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= 4'b0000;
            dbus_wdata <= '0;
            wb_rw      <= 5'd0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= '0;
            op_q       <= OP_NONE;
            lo_q       <= 2'b00;
`ifdef MEM_ALIGN_EXC_EN
            excp_q     <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_EXC_EN
            excp_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (op == OP_NONE) begin
                        wb_rw    <= mem_rw_i;
                        wb_wreg  <= mem_wreg_i;
                        wb_wdata <= mem_wdata_i;
                    end else if (misalign) begin
                        wb_wreg <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
                        excp_q  <= 1'b1;
`endif
                    end else begin
                        state      <= S_WAIT;
                        dbus_req   <= 1'b1;
                        dbus_we    <= (op == OP_SB) || (op == OP_SW);
                        dbus_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        dbus_sel   <= sel_c;
                        dbus_wdata <= wdata_c;
                        wb_wreg    <= 1'b0;
                        op_q       <= op;
                        lo_q       <= mem_addr_i[1:0];
                    end
                end
                default: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        state    <= S_IDLE;
                        if (op_q != OP_SB && op_q != OP_SW) begin
                            wb_rw    <= mem_rw_i;
                            wb_wreg  <= 1'b1;
                            wb_wdata <= load_data;
                        end else begin
                            wb_wreg <= 1'b0;
                        end
                    end else begin
                        wb_wreg <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: reset, pass-through, loads/stores with lane checks,
// misaligned word access in whichever build (MEM_ALIGN_EXC_EN) is compiled.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_rw_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        stall_req;
    logic [4:0]  wb_rw;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        excp_o;

    int total = 0;
    int bad   = 0;

    // Per-access observations filled in by run_access.
    int          n_stall;
    int          n_wb;
    logic        s_req, s_we, held_ok, req_after, excp_seen;
    logic [31:0] s_addr, s_wdata, s_data;
    logic [3:0]  s_sel;
    logic [4:0]  s_rw;

    mem_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .mem_rw_i    (mem_rw_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_sel    (dbus_sel),
        .dbus_wdata  (dbus_wdata),
        .dbus_ack    (dbus_ack),
        .dbus_rdata  (dbus_rdata),
        .stall_req   (stall_req),
        .wb_rw       (wb_rw),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .excp_o      (excp_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_op_i    = 3'd0;
        mem_rw_i    = 5'd0;
        mem_wreg_i  = 1'b0;
        mem_wdata_i = 32'd0;
        mem_addr_i  = 32'd0;
        mem_sdata_i = 32'd0;
        dbus_ack    = 1'b0;
        dbus_rdata  = 32'd0;
    endtask

    // One access: request cycle, `waits` WAIT cycles without ack, one ack cycle, one idle cycle.
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int waits);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        mem_rw_i    = 5'd9;
        mem_wreg_i  = 1'b1;
        mem_wdata_i = 32'hBAD0_BAD0;
        dbus_ack    = 1'b0;
        dbus_rdata  = 32'h5A5A_5A5A;
        n_stall = 0; n_wb = 0; held_ok = 1'b1; s_data = 32'd0; s_rw = 5'd0; excp_seen = 1'b0;
        #1;
        if (stall_req) n_stall++;
        tick();
        s_req = dbus_req; s_we = dbus_we; s_addr = dbus_addr; s_sel = dbus_sel; s_wdata = dbus_wdata;
        if (wb_wreg) n_wb++;
        if (excp_o) excp_seen = 1'b1;
        for (int i = 0; i < waits; i++) begin
            #1;
            if (stall_req) n_stall++;
            tick();
            if (wb_wreg) n_wb++;
            if (dbus_req !== s_req || dbus_addr !== s_addr || dbus_sel !== s_sel || dbus_wdata !== s_wdata)
                held_ok = 1'b0;
        end
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
        #1;
        if (stall_req) n_stall++;
        tick();
        if (wb_wreg) begin n_wb++; s_data = wb_wdata; s_rw = wb_rw; end
        req_after = dbus_req;
        idle_inputs();
        tick();
        if (wb_wreg) n_wb++;
        if (excp_o) excp_seen = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_req",   dbus_req,   0);
        check("rst_sel",   dbus_sel,   0);
        check("rst_wreg",  wb_wreg,    0);
        check("rst_wdata", wb_wdata,   0);
        check("rst_excp",  excp_o,     0);

        // ALU pass-through
        mem_op_i = 3'd0; mem_rw_i = 5'd5; mem_wreg_i = 1'b1; mem_wdata_i = 32'h1234_5678;
        #1;
        check("pt_stall", stall_req, 0);
        tick();
        check("pt_rw",    wb_rw,    5);
        check("pt_wreg",  wb_wreg,  1);
        check("pt_wdata", wb_wdata, 32'h1234_5678);
        check("pt_req",   dbus_req, 0);
        idle_inputs();
        tick();

        // LB with three non-ack WAIT cycles
        run_access(3'd1, 32'h0000_1001, 32'd0, 32'h1182_3344, 3);
        check("lb_req",   s_req,   1);
        check("lb_we",    s_we,    0);
        check("lb_addr",  s_addr,  32'h0000_1000);
        check("lb_sel",   s_sel,   4'b0100);
        check("lb_hold",  held_ok, 1);
        check("lb_stall", n_stall, 4);
        check("lb_nwb",   n_wb,    1);
        check("lb_data",  s_data,  32'hFFFF_FF82);
        check("lb_rw",    s_rw,    9);
        check("lb_reqlo", req_after, 0);

        // LHU immediate ack
        run_access(3'd4, 32'h0000_2002, 32'd0, 32'hAAAA_8001, 0);
        check("lhu_sel",   s_sel,   4'b0011);
        check("lhu_stall", n_stall, 1);
        check("lhu_data",  s_data,  32'h0000_8001);

        // LH upper half, sign-extended
        run_access(3'd3, 32'h0000_2000, 32'd0, 32'h8001_7F00, 1);
        check("lh_sel",  s_sel,  4'b1100);
        check("lh_data", s_data, 32'hFFFF_8001);

        // LBU lane 3, zero-extended
        run_access(3'd2, 32'h0000_1003, 32'd0, 32'h1234_56F0, 0);
        check("lbu_sel",  s_sel,  4'b0001);
        check("lbu_data", s_data, 32'h0000_00F0);

        // LW aligned
        run_access(3'd5, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 2);
        check("lw_sel",  s_sel,  4'b1111);
        check("lw_data", s_data, 32'hCAFE_F00D);
        check("lw_nwb",  n_wb,   1);

        // SB lane replication
        run_access(3'd6, 32'h0000_3003, 32'h0000_00AB, 32'd0, 1);
        check("sb_we",    s_we,    1);
        check("sb_sel",   s_sel,   4'b0001);
        check("sb_wdata", s_wdata, 32'hABAB_ABAB);
        check("sb_addr",  s_addr,  32'h0000_3000);
        check("sb_nwb",   n_wb,    0);

        // SW
        run_access(3'd7, 32'h0000_3004, 32'hDEAD_BEEF, 32'd0, 0);
        check("sw_we",    s_we,    1);
        check("sw_sel",   s_sel,   4'b1111);
        check("sw_wdata", s_wdata, 32'hDEAD_BEEF);
        check("sw_nwb",   n_wb,    0);

        // Misaligned LW
`ifdef MEM_ALIGN_EXC_EN
        mem_op_i = 3'd5; mem_addr_i = 32'h0000_4002; mem_rw_i = 5'd9; mem_wreg_i = 1'b1;
        #1;
        check("mis_stall", stall_req, 0);
        tick();
        check("mis_req",  dbus_req, 0);
        check("mis_excp", excp_o,   1);
        check("mis_wreg", wb_wreg,  0);
        idle_inputs();
        tick();
        check("mis_excp_end", excp_o,   0);
        check("mis_req_end",  dbus_req, 0);
`else
        run_access(3'd5, 32'h0000_4002, 32'd0, 32'h0102_0304, 0);
        check("mis_addr", s_addr,    32'h0000_4000);
        check("mis_sel",  s_sel,     4'b1111);
        check("mis_data", s_data,    32'h0102_0304);
        check("mis_excp", excp_seen, 0);
`endif

        // Reset while a transaction is outstanding
        mem_op_i = 3'd1; mem_addr_i = 32'h0000_1000; mem_rw_i = 5'd3; mem_wreg_i = 1'b1;
        tick();
        check("mr_req_pre", dbus_req, 1);
        rst = 1'b1;
        tick();
        check("mr_req",   dbus_req,  0);
        check("mr_addr",  dbus_addr, 0);
        check("mr_wreg",  wb_wreg,   0);
        tick();
        rst = 1'b0;
        idle_inputs();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        tick();
        check("mr_ack_wreg", wb_wreg,  0);
        check("mr_ack_req",  dbus_req, 0);
        check("mr_ack_data", wb_wdata, 0);
        dbus_ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
